// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one carry-lookahead group per pipeline stage, valid/ready flow control; CLA_OVERFLOW_EN adds signed overflow
module pipelined_cla_adder #(
    parameter int DATA_WIDTH  = 16,
    parameter int GROUP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int NUM_GROUPS = DATA_WIDTH / GROUP_WIDTH;
    localparam int MSB        = DATA_WIDTH - 1;

    if (GROUP_WIDTH < 1 || GROUP_WIDTH > 8 || DATA_WIDTH < 1 || (DATA_WIDTH % GROUP_WIDTH) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: DATA_WIDTH must be a nonzero multiple of GROUP_WIDTH, GROUP_WIDTH in 1..8");
    end

    // A held result freezes the whole pipeline; nothing moves until it is taken.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : stage
        logic [DATA_WIDTH-1:0]  a_i, b_i, s_i, s_n, a_q, b_q, s_q;
        logic                   c_i, v_i, c_q, v_q;
        logic [GROUP_WIDTH-1:0] g, p;
        logic [GROUP_WIDTH:0]   c;
`ifdef CLA_OVERFLOW_EN
        logic sa_i, sb_i, sa_q, sb_q;
`endif
        if (k == 0) begin : src
            assign a_i = a;
            assign b_i = b;
            assign s_i = '0;
            assign c_i = cin;
            assign v_i = in_valid;
`ifdef CLA_OVERFLOW_EN
            assign sa_i = a[MSB];
            assign sb_i = b[MSB];
`endif
        end else begin : src
            assign a_i = stage[k-1].a_q;
            assign b_i = stage[k-1].b_q;
            assign s_i = stage[k-1].s_q;
            assign c_i = stage[k-1].c_q;
            assign v_i = stage[k-1].v_q;
`ifdef CLA_OVERFLOW_EN
            assign sa_i = stage[k-1].sa_q;
            assign sb_i = stage[k-1].sb_q;
`endif
        end

        assign g = a_i[k*GROUP_WIDTH +: GROUP_WIDTH] & b_i[k*GROUP_WIDTH +: GROUP_WIDTH];
        assign p = a_i[k*GROUP_WIDTH +: GROUP_WIDTH] ^ b_i[k*GROUP_WIDTH +: GROUP_WIDTH];

        // Lookahead carries flattened combinationally from the group carry-in; this group's sum slice is merged into the partial sum.
        always_comb begin
            c[0] = c_i;
            for (int i = 0; i < GROUP_WIDTH; i++) c[i+1] = g[i] | (p[i] & c[i]);
            s_n = s_i;
            s_n[k*GROUP_WIDTH +: GROUP_WIDTH] = p ^ c[GROUP_WIDTH-1:0];
        end

        // Stage register: partial sum, group carry-out, valid and skewed operands advance together unless stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
`ifdef CLA_OVERFLOW_EN
                sa_q <= 1'b0;
                sb_q <= 1'b0;
`endif
            end else if (!stall) begin
                v_q <= v_i;
                c_q <= c[GROUP_WIDTH];
                s_q <= s_n;
                a_q <= a_i;
                b_q <= b_i;
`ifdef CLA_OVERFLOW_EN
                sa_q <= sa_i;
                sb_q <= sb_i;
`endif
            end
        end
    end

    assign out_valid = stage[NUM_GROUPS-1].v_q;
    assign sum       = stage[NUM_GROUPS-1].s_q;
    assign cout      = stage[NUM_GROUPS-1].c_q;
`ifdef CLA_OVERFLOW_EN
    assign ovf = (stage[NUM_GROUPS-1].sa_q == stage[NUM_GROUPS-1].sb_q) && (sum[MSB] != stage[NUM_GROUPS-1].sa_q);
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for the 16-bit, 4-group pipelined CLA adder
module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    int           tests = 0, fails = 0;
    logic [W+1:0] q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.DATA_WIDTH(W), .GROUP_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] r;
        logic       o;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
`ifdef CLA_OVERFLOW_EN
        o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
`else
        o = 1'b0;
`endif
        return {o, r};
    endfunction

    // Called just after a falling edge with inputs set: records both handshakes, then advances one cycle.
    task automatic tick();
        logic [W+1:0] e;
        #1;
        if (!rst && in_valid && in_ready) q.push_back(model(a, b, cin));
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got sum=%h cout=%b with nothing pending", sum, cout);
            end else begin
                e = q.pop_front();
                if ({ovf, cout, sum} !== e) begin
                    fails++;
                    $display("FAIL result: got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
                             ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d results still pending, expected 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        tick(); tick();
        tests++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got out_valid=%b sum=%h cout=%b ovf=%b, expected all 0", out_valid, sum, cout, ovf);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_full_carry();
        int lat;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL full_carry_latency: got %0d cycles, expected 4", lat);
        end
        tests++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            fails++;
            $display("FAIL full_carry_value: got sum=%h cout=%b, expected sum=0000 cout=1", sum, cout);
        end
        tick();
        drain("full_carry");
    endtask

    task automatic test_overflow();
        logic eo;
`ifdef CLA_OVERFLOW_EN
        eo = 1'b1;
`else
        eo = 1'b0;
`endif
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        tests++;
        if (out_valid !== 1'b1 || sum !== 16'h8000 || cout !== 1'b0 || ovf !== eo) begin
            fails++;
            $display("FAIL overflow: got valid=%b sum=%h cout=%b ovf=%b, expected valid=1 sum=8000 cout=0 ovf=%b",
                     out_valid, sum, cout, ovf, eo);
        end
        drain("overflow");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta[6] = '{16'h000A, 16'h00FF, 16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F};
        logic [W-1:0] tb[6] = '{16'h0005, 16'h0001, 16'h4321, 16'hFFFF, 16'h8000, 16'hF0F0};
        logic         tc[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int first = -1, last = -1, cnt = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 26; n++) begin
            if (n < 6) begin
                a = ta[n]; b = tb[n]; cin = tc[n]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            if (out_valid) begin
                if (first < 0) first = n;
                last = n;
                cnt++;
            end
            tick();
        end
        tests++;
        if (cnt !== 6 || last - first !== 5) begin
            fails++;
            $display("FAIL back_to_back: got %0d valid cycles spanning %0d, expected 6 spanning 6", cnt, last - first + 1);
        end
        drain("back_to_back");
    endtask

    task automatic test_stall();
        logic [W+2:0] snap;
        int n;
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0101; b = 16'h2020; cin = 1'b0;
        for (n = 0; n < 20 && !out_valid; n++) begin
            tick();
            a = a + 16'h0303; b = b ^ 16'h0F0F; cin = ~cin;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_fill: got out_valid=%b, expected 1 within 20 cycles", out_valid);
        end
        snap = {out_valid, ovf, cout, sum};
        for (int i = 0; i < 5; i++) begin
            tick();
            a = a + 16'h0303;
            tests++;
            if (in_ready !== 1'b0 || {out_valid, ovf, cout, sum} !== snap) begin
                fails++;
                $display("FAIL stall_hold%0d: got in_ready=%b {v,ovf,cout,sum}=%h, expected in_ready=0 %h",
                         i, in_ready, {out_valid, ovf, cout, sum}, snap);
            end
        end
        drain("stall");
    endtask

    task automatic test_reset_flush();
        int stale = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h1000 * (i + 1); b = 16'h0011; cin = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL flush_outputs: got out_valid=%b sum=%h cout=%b, expected 0/0000/0", out_valid, sum, cout);
        end
        q.delete();
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            tick();
        end
        tests++;
        if (stale !== 0) begin
            fails++;
            $display("FAIL flush_stale: got %0d stale valid cycles, expected 0", stale);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
        end
        drain("random");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_carry();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
